// File: rtl/diram_phy_responder_pkg.sv
// Shared types and constants for the DiRAM PHY responder.
// Contents:
//   - geometry constants (channels, banks, widths, burst length, read latency)
//   - cmd_e         : decoded bus command (ACT/RD/WR/PRE)
//   - engine states : per-channel burst engine encoding
//   - bank_state_t  : open flag plus last activated row
//   - decode_cmd()  : {cmd1, cmd0} -> cmd_e
package diram_phy_pkg;

  localparam int unsigned NumChannels = 2;
  localparam int unsigned NumBanks    = 8;
  localparam int unsigned BankW       = $clog2(NumBanks);
  localparam int unsigned AddrW       = 13;
  localparam int unsigned DataW       = 256;
  localparam int unsigned ClkGroups   = 2;
  localparam int unsigned BurstLen    = 2;
  localparam int unsigned RdLat       = 4;
  localparam int unsigned MemColW     = 4;

  localparam int unsigned SlotW    = (NumChannels > 1) ? $clog2(NumChannels) : 1;
  localparam int unsigned BeatW    = (BurstLen > 1) ? $clog2(BurstLen) : 1;
  localparam int unsigned CntW     = $clog2(RdLat + 1);
  localparam int unsigned MemAw    = SlotW + BankW + MemColW;
  localparam int unsigned MemDepth = NumChannels * NumBanks * (2 ** MemColW);

  typedef enum logic [1:0] {
    CmdAct = 2'b00,
    CmdRd  = 2'b01,
    CmdWr  = 2'b10,
    CmdPre = 2'b11
  } cmd_e;

  // Burst engine states; plain constants so legacy tools can consume them.
  typedef logic [1:0] eng_state_t;
  localparam eng_state_t StIdle    = 2'd0;
  localparam eng_state_t StWrBurst = 2'd1;
  localparam eng_state_t StRdWait  = 2'd2;
  localparam eng_state_t StRdBurst = 2'd3;

  typedef struct packed {
    logic             is_open;
    logic [AddrW-1:0] row;
  } bank_state_t;

  function automatic cmd_e decode_cmd(input logic cmd1, input logic cmd0);
    return cmd_e'({cmd1, cmd0});
  endfunction

endpackage

// File: rtl/diram_phy_responder_if.sv
// MMC <-> PHY command/data bus.
//   dfi__phy__*  : command stream and write data, driven by the controller (master)
//   phy__dfi__*  : read return, slot tag and error pulse, driven by the responder (slave)
interface diram_phy_responder_if;
  import diram_phy_pkg::*;

  logic                 dfi__phy__cs;
  logic                 dfi__phy__cmd1;
  logic                 dfi__phy__cmd0;
  logic [BankW-1:0]     dfi__phy__bank;
  logic [AddrW-1:0]     dfi__phy__addr;
  logic [DataW-1:0]     dfi__phy__data;
  logic [ClkGroups-1:0] phy__dfi__valid;
  logic [DataW-1:0]     phy__dfi__data;
  logic [SlotW-1:0]     phy__dfi__slot;
  logic                 phy__dfi__err;

  modport master (
    output dfi__phy__cs, dfi__phy__cmd1, dfi__phy__cmd0, dfi__phy__bank, dfi__phy__addr,
           dfi__phy__data,
    input  phy__dfi__valid, phy__dfi__data, phy__dfi__slot, phy__dfi__err
  );

  modport slave (
    input  dfi__phy__cs, dfi__phy__cmd1, dfi__phy__cmd0, dfi__phy__bank, dfi__phy__addr,
           dfi__phy__data,
    output phy__dfi__valid, phy__dfi__data, phy__dfi__slot, phy__dfi__err
  );

endinterface

// File: rtl/diram_phy_responder_bank_tracker.sv
// Open-row table for every (channel, bank).
// Ports:
//   clk_i   : clock
//   rst_i   : synchronous active-high reset, closes every bank
//   upd_i   : apply cmd_i to the addressed entry (ACT opens, PRE closes)
//   cmd_i   : decoded command
//   chan_i  : channel owning the current slot
//   bank_i  : addressed bank
//   row_i   : row to record on ACT
//   open_o  : addressed bank is currently open
module diram_phy_bank_tracker
  import diram_phy_pkg::*;
(
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             upd_i,
  input  cmd_e             cmd_i,
  input  logic [SlotW-1:0] chan_i,
  input  logic [BankW-1:0] bank_i,
  input  logic [AddrW-1:0] row_i,
  output logic             open_o
);

  bank_state_t tbl_q [NumChannels*NumBanks];

  logic [SlotW+BankW-1:0] idx;
  assign idx    = {chan_i, bank_i};
  assign open_o = tbl_q[idx].is_open;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int i = 0; i < NumChannels * NumBanks; i++) begin
        tbl_q[i] <= '0;
      end
    end else if (upd_i) begin
      // ACT on an open bank simply replaces the row; the error is flagged upstream.
      if (cmd_i == CmdAct) begin
        tbl_q[idx].is_open <= 1'b1;
        tbl_q[idx].row     <= row_i;
      end else if (cmd_i == CmdPre) begin
        tbl_q[idx].is_open <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/diram_phy_responder.sv
// DRAM-side responder for the slot-multiplexed MMC->PHY bus.
// Ports:
//   clk           : single clock, one bus slot per cycle
//   reset_poweron : synchronous active-high reset
//   bus           : slave side of the command/data bus
// Each cycle belongs to channel slot_q. Commands are checked against the channel's burst
// engine and bank table; write beats commit and read beats fetch in the owning slot.
// Outputs are registered, so phy__dfi__slot tags the channel each returned beat belongs to.
module diram_phy_responder
  import diram_phy_pkg::*;
(
  input logic                  clk,
  input logic                  reset_poweron,
  diram_phy_responder_if.slave bus
);

  logic [SlotW-1:0] slot_q, slot_d;
  logic             valid_q;
  logic [DataW-1:0] rdata_q;
  logic [SlotW-1:0] oslot_q;
  logic             err_q, err_d;

  logic [DataW-1:0] mem [MemDepth];

  cmd_e               cmd;
  logic               cs;
  logic [BankW-1:0]   in_bank;
  logic [MemColW-1:0] in_col;
  logic               bank_open;
  logic               trk_upd;
  logic               acc_rd, acc_wr;
  eng_state_t         cur_st;
  logic [MemColW-1:0] col_beat;
  logic               mem_we, mem_re;
  logic [MemAw-1:0]   mem_waddr, mem_raddr;

  eng_state_t         st_all   [NumChannels];
  logic [BankW-1:0]   bank_all [NumChannels];
  logic [MemColW-1:0] col_all  [NumChannels];
  logic [BeatW-1:0]   beat_all [NumChannels];

  assign cs      = bus.dfi__phy__cs;
  assign cmd     = decode_cmd(bus.dfi__phy__cmd1, bus.dfi__phy__cmd0);
  assign in_bank = bus.dfi__phy__bank;
  assign in_col  = bus.dfi__phy__addr[MemColW-1:0];

  assign slot_d = (slot_q == SlotW'(NumChannels - 1)) ? '0 : slot_q + 1'b1;

  diram_phy_bank_tracker u_bank_tracker (
    .clk_i  (clk),
    .rst_i  (reset_poweron),
    .upd_i  (trk_upd),
    .cmd_i  (cmd),
    .chan_i (slot_q),
    .bank_i (in_bank),
    .row_i  (bus.dfi__phy__addr),
    .open_o (bank_open)
  );

  always_comb begin
    cur_st  = st_all[slot_q];
    err_d   = 1'b0;
    trk_upd = 1'b0;
    acc_rd  = 1'b0;
    acc_wr  = 1'b0;
    if (cs) begin
      if (cur_st != StIdle) begin
        err_d = 1'b1;
      end else begin
        unique case (cmd)
          CmdAct: begin
            err_d   = bank_open;
            trk_upd = 1'b1;
          end
          CmdPre: trk_upd = 1'b1;
          CmdRd: begin
            err_d  = ~bank_open;
            acc_rd = bank_open;
          end
          CmdWr: begin
            err_d  = ~bank_open;
            acc_wr = bank_open;
          end
          default: ;
        endcase
      end
    end

    // Column wraps inside the kept column bits.
    col_beat  = col_all[slot_q] + MemColW'(beat_all[slot_q]);
    mem_we    = ~reset_poweron & (acc_wr | (cur_st == StWrBurst));
    mem_waddr = acc_wr ? {slot_q, in_bank, in_col} : {slot_q, bank_all[slot_q], col_beat};
    mem_re    = ~reset_poweron & (cur_st == StRdBurst);
    mem_raddr = {slot_q, bank_all[slot_q], col_beat};
  end

  for (genvar ch = 0; ch < NumChannels; ch++) begin : g_eng
    eng_state_t         st_q, st_d;
    logic [CntW-1:0]    cnt_q, cnt_d;
    logic [BankW-1:0]   bank_q, bank_d;
    logic [MemColW-1:0] col_q, col_d;
    logic [BeatW-1:0]   beat_q, beat_d;
    logic               own;

    assign own = (slot_q == SlotW'(ch));

    always_comb begin
      st_d   = st_q;
      cnt_d  = cnt_q;
      bank_d = bank_q;
      col_d  = col_q;
      beat_d = beat_q;
      if (own) begin
        case (st_q)
          StIdle: begin
            if (acc_rd || acc_wr) begin
              bank_d = in_bank;
              col_d  = in_col;
              beat_d = '0;
            end
            if (acc_rd) begin
              if (RdLat > 1) begin
                st_d  = StRdWait;
                cnt_d = CntW'(RdLat - 1);
              end else begin
                st_d = StRdBurst;
              end
            end else if (acc_wr) begin
              // Beat 0 commits with the command itself.
              beat_d = BeatW'(1);
              st_d   = (BurstLen > 1) ? StWrBurst : StIdle;
            end
          end
          StWrBurst, StRdBurst: begin
            beat_d = beat_q + 1'b1;
            if (beat_q == BeatW'(BurstLen - 1)) st_d = StIdle;
          end
          StRdWait: begin
            cnt_d = cnt_q - 1'b1;
            if (cnt_q == CntW'(1)) st_d = StRdBurst;
          end
          default: st_d = StIdle;
        endcase
      end
    end

    always_ff @(posedge clk) begin
      if (reset_poweron) begin
        st_q   <= StIdle;
        cnt_q  <= '0;
        bank_q <= '0;
        col_q  <= '0;
        beat_q <= '0;
      end else begin
        st_q   <= st_d;
        cnt_q  <= cnt_d;
        bank_q <= bank_d;
        col_q  <= col_d;
        beat_q <= beat_d;
      end
    end

    assign st_all[ch]   = st_q;
    assign bank_all[ch] = bank_q;
    assign col_all[ch]  = col_q;
    assign beat_all[ch] = beat_q;
  end

  // Storage is deliberately not reset so committed beats survive a mid-burst reset.
  always_ff @(posedge clk) begin
    if (mem_we) mem[mem_waddr] <= bus.dfi__phy__data;
  end

  // Read sees the pre-write contents; no same-slot bypass.
  always_ff @(posedge clk) begin
    if (reset_poweron) begin
      slot_q  <= '0;
      valid_q <= 1'b0;
      rdata_q <= '0;
      oslot_q <= '0;
      err_q   <= 1'b0;
    end else begin
      slot_q  <= slot_d;
      valid_q <= mem_re;
      rdata_q <= mem_re ? mem[mem_raddr] : '0;
      oslot_q <= slot_q;
      err_q   <= err_d;
    end
  end

  assign bus.phy__dfi__valid = {ClkGroups{valid_q}};
  assign bus.phy__dfi__data  = rdata_q;
  assign bus.phy__dfi__slot  = oslot_q;
  assign bus.phy__dfi__err   = err_q;

endmodule
